// File: rtl/sequence_generator_1010.sv
// Serial frame transmitter for the overlapping "1010" detector link.
// Accepts one DATA_W-bit word per valid/ready handshake. It then sends a
// 4-bit preamble (1,0,1,0), the payload MSB first, and an optional run of
// GAP_CYCLES zeros. After that it returns to IDLE for at least one cycle.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// (the XOR of the payload bits) after the payload LSB.
module sequence_generator_1010 #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int PRE_LEN   = 4;
  localparam int CNT_MAX_A = (DATA_W > PRE_LEN) ? DATA_W : PRE_LEN;
  localparam int CNT_MAX   = (GAP_CYCLES > CNT_MAX_A) ? GAP_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam bit HAS_GAP   = (GAP_CYCLES > 0);

  typedef logic [CNT_W-1:0] cnt_t;

  // The counter holds the index of the bit currently on data_out within its state
  localparam cnt_t PRE_LAST = cnt_t'(PRE_LEN - 1);
  localparam cnt_t PAY_LAST = cnt_t'(DATA_W - 1);
  localparam cnt_t GAP_LAST = cnt_t'(HAS_GAP ? GAP_CYCLES - 1 : 0);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_PAY  = 3'd2,
    S_PAR  = 3'd3,
    S_GAP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_PAY  = 3'd2,
    S_GAP  = 3'd4
  } state_t;
`endif

  state_t            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dout_q, dout_d;
  logic              accept;
`ifdef SEQ_GEN_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // The handshake is accepted only in IDLE. Words offered at other times are ignored.
  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign accept     = load_valid && load_ready;
  assign data_out   = dout_q;

  // frame_done follows the state that owns the final bit, so it lines up with data_out
`ifdef SEQ_GEN_PARITY_EN
  assign frame_done = (state_q == S_PAR);
`else
  assign frame_done = (state_q == S_PAY) && (cnt_q == PAY_LAST);
`endif

  // Next-state logic. dout_d is the bit that data_out presents in the following cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    dout_d   = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_PRE;
          cnt_d    = '0;
          dout_d   = 1'b1;
          shreg_d  = load_data;
`ifdef SEQ_GEN_PARITY_EN
          parity_d = ^load_data;
`endif
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_PAY;
          cnt_d   = '0;
          dout_d  = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end else begin
          // Preamble index k carries bit 1 when k is even, so the next bit equals cnt_q[0]
          cnt_d  = cnt_q + CNT_ONE;
          dout_d = cnt_q[0];
        end
      end
      S_PAY: begin
        if (cnt_q == PAY_LAST) begin
          cnt_d   = '0;
          shreg_d = '0;
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PAR;
          dout_d  = parity_q;
`else
          state_d = HAS_GAP ? S_GAP : S_IDLE;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          dout_d  = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        cnt_d    = '0;
        parity_d = 1'b0;
        state_d  = HAS_GAP ? S_GAP : S_IDLE;
      end
`endif
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  // State, counter, shift register and output bit. Reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      dout_q   <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
`ifdef SEQ_GEN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_sequence_generator_1010.sv
// Scoreboard bench for sequence_generator_1010 (DATA_W=8, GAP_CYCLES=3).
// Each stimulus step queues the outputs expected after its clock edge.
// A monitor pops one entry per cycle and compares it on the falling edge.
module tb_sequence_generator_1010;

  localparam int DATA_W = 8;
  localparam int GAP    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              data_out;
  logic              busy;
  logic              frame_done;

  // Each entry holds {data_out, frame_done, load_ready, busy}
  logic [3:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mon_exp;
  logic [3:0] mon_act;
  string      mon_tag;

  sequence_generator_1010 #(
    .DATA_W    (DATA_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Monitor: one observation per cycle, taken away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {data_out, frame_done, load_ready, busy};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: {data_out,frame_done,load_ready,busy} got %b expected %b at %0t",
                 mon_tag, mon_act, mon_exp, $time);
      end
    end
  end

  // Drive the inputs for one edge and queue the outputs expected after that edge
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic e_do, input logic e_done, input logic e_rdy,
                      input logic e_busy, input string tag);
    rst        = r;
    load_valid = v;
    load_data  = d;
    exp_q.push_back({e_do, e_done, e_rdy, e_busy});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  // Send one frame starting from IDLE. bits holds the hand-computed preamble and
  // payload (first bit in bit 11), and par is the expected parity bit. While the
  // generator is busy, nv/nd are driven on the load inputs. The task ends with the
  // first IDLE cycle after the frame.
  task automatic frame(input logic [DATA_W-1:0] w, input logic [11:0] bits,
                       input logic par, input logic nv, input logic [DATA_W-1:0] nd,
                       input string tag);
    logic [12:0] seq;
    int          len;
    seq = {bits, par};
`ifdef SEQ_GEN_PARITY_EN
    len = 13;
`else
    len = 12;
`endif
    for (int i = 0; i < len; i++) begin
      if (i == 0) step(1'b0, 1'b1, w, seq[12], 1'b0, 1'b0, 1'b1, tag);
      else        step(1'b0, nv, nd, seq[12-i], (i == len - 1), 1'b0, 1'b1, tag);
    end
    for (int g = 0; g < GAP; g++) step(1'b0, nv, nd, 1'b0, 1'b0, 1'b0, 1'b1, tag);
    step(1'b0, nv, nd, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
    repeat (10) idle("idle");

    // Single frame: 0xC5 -> 1010 1100 0101, parity 0
    frame(8'hC5, 12'b1010_1100_0101, 1'b0, 1'b0, 8'h00, "c5");
    idle("idle_c5");

    // load_valid held high: 0xFF, then 0x00 on the first IDLE cycle
    frame(8'hFF, 12'b1010_1111_1111, 1'b0, 1'b1, 8'h00, "ff_held");
    frame(8'h00, 12'b1010_0000_0000, 1'b0, 1'b0, 8'h00, "zero_b2b");
    idle("idle_b2b");

    // 0xAA offered throughout the 0x3C frame is ignored, then accepted on IDLE
    frame(8'h3C, 12'b1010_0011_1100, 1'b0, 1'b1, 8'hAA, "busy_3c");
    frame(8'hAA, 12'b1010_1010_1010, 1'b0, 1'b0, 8'h00, "aa");
    idle("idle_aa");

    // Reset while payload bit 3 of 0xF0 is on the line
    step(1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, "f0_pre");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "f0_pre");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "f0_pre");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "f0_pre");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "f0_pay");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "f0_pay");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "f0_pay");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "f0_pay3");
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "midrst");
    idle("post_rst");
    idle("post_rst");

    // Fresh frame after reset: 0x81 -> 1010 1000 0001
    frame(8'h81, 12'b1010_1000_0001, 1'b0, 1'b0, 8'h00, "81");

    // Parity cases: 0x01 has parity 1, 0x03 has parity 0
    frame(8'h01, 12'b1010_0000_0001, 1'b1, 1'b0, 8'h00, "par01");
    frame(8'h03, 12'b1010_0000_0011, 1'b0, 1'b0, 8'h00, "par03");
    repeat (3) idle("idle_end");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending expectations %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
